reg_op_sequencer: RTL and testbench
===================================

// Module: reg_op_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the 8x8 register file plus a small ALU.
//  Accepts one register-register or immediate command per handshake.
//  Drives register file addresses, samples its read data, computes the result and
//  issues a single-cycle write-back.
//  Sits between the instruction decode logic and the register file; it is the
//  register file's only address/write driver.
// PARAMETERS
//  DATA_W  8  register/ALU data width
//  ADDR_W  3  register address width (2**ADDR_W registers)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       synchronous reset, active-low
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       sequencer can accept (high only in IDLE)
//  cmd_op       in   3       000 MOV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 LDI, 111 CMP
//  cmd_rd       in   ADDR_W  destination / first source register
//  cmd_rs       in   ADDR_W  second source register
//  cmd_imm      in   DATA_W  immediate for LDI
//  rf_op1       out  ADDR_W  register file port-1 address (also write address)
//  rf_op2       out  ADDR_W  register file port-2 address
//  rf_data      out  DATA_W  write data
//  rf_en_write  out  1       write enable, one cycle per write-back
//  rf_out1      in   DATA_W  register file read data, port 1 (combinational)
//  rf_out2      in   DATA_W  register file read data, port 2
//  done         out  1       one-cycle pulse: command retired
//  result       out  DATA_W  last computed result, held until next EXEC
//  flag_z       out  1       result == 0
//  flag_c       out  1       ADD carry-out / SUB borrow; 0 for logic ops
// BEHAVIOUR
//  - States: IDLE, READ, EXEC, WRITE. Accept = cmd_valid & cmd_ready, in IDLE only;
//    op/rd/rs/imm are latched at accept. cmd_valid while busy is ignored.
//  - IDLE -> READ on accept (LDI: IDLE -> EXEC). READ: rf_op1=rd, rf_op2=rs;
//    rf_out1/rf_out2 are captured into operand registers at the edge leaving READ.
//  - EXEC: result = f(A=reg[rd], B=reg[rs]); MOV -> B, ADD -> A+B, SUB -> A-B,
//    logic ops bitwise, LDI -> imm. flag_z/flag_c update on every op except LDI,
//    which leaves both flags unchanged.
//    EXEC -> WRITE, except CMP (computes A-B, flags only) -> IDLE.
//  - WRITE: rf_op1=rd, rf_data=result, rf_en_write=1 for exactly one cycle -> IDLE.
//  - done pulses high during the first IDLE cycle after retirement; cmd_ready is
//    also high in that cycle, so back-to-back accepts are legal.
//  - Latency, accept edge to done cycle: ALU ops/MOV 4 cycles, LDI 3 cycles, CMP 3 cycles.
//  - Arithmetic is DATA_W bits; carry/borrow is the bit DATA_W of the extended add/sub.
//  - rf_en_write = (state==WRITE) & rst_n: reset asserted in WRITE suppresses the write.
//  - rf_op1/rf_op2 hold their last value in IDLE; rf_data holds result.
//  - rst_n low at any edge: state IDLE, cmd_ready=1, done=0, rf_en_write=0,
//    rf_op1=rf_op2=0, rf_data=0, result=0, flag_z=0, flag_c=0. An in-flight command is
//    dropped with no done pulse.
// CONFIGURATION
//  SEQ_SAT_EN defined: ADD clamps to all-ones on carry; SUB clamps to 0 on borrow.
//    CMP is never clamped. flag_c still reports the unclamped carry/borrow.
//    flag_z reflects the clamped result.
//  SEQ_SAT_EN undefined: ADD/SUB wrap modulo 2**DATA_W.
// TESTING
//  1. Reset with cmd_valid=1 -> all outputs at reset values; no accept until rst_n=1.
//  2. LDI rd=3 imm=0xA5 -> rf_en_write 1 cycle with rf_op1=3, rf_data=0xA5; done at cycle 3.
//  3. ADD r2(0xF0)+r5(0x20) -> rf_data=0x10, flag_c=1, flag_z=0; with SEQ_SAT_EN: rf_data=0xFF.
//  4. CMP r1(0x01),r1 -> flag_z=1, flag_c=0; no rf_en_write; done at cycle 3.
//  5. Back-to-back: MOV r4<-r6 accepted in the done cycle of the prior op -> no bubble;
//     second write is correct. cmd_valid pulses while busy are not accepted.
//  6. rst_n low during WRITE of SUB -> rf_en_write stays 0; no done; target register unchanged.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// Multi-cycle register-file sequencer with a small ALU (IDLE/READ/EXEC/WRITE).
// Optional feature macro: SEQ_SAT_EN (saturating ADD/SUB write-back results).
module reg_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_op1,
  output logic [ADDR_W-1:0] rf_op2,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_en_write,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [2:0]          op_r;
  logic [ADDR_W-1:0]   op1_r, op2_r;
  logic [DATA_W-1:0]   imm_r, a_r, b_r, result_r;
  logic                z_r, c_r, done_r;

  logic [DATA_W:0]     sum_s, diff_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_c_s, flags_upd_s;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt_s = (cmd_op == OP_LDI) ? S_EXEC : S_READ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_READ:  state_nxt_s = S_EXEC;
      S_EXEC:  state_nxt_s = (op_r == OP_CMP) ? S_IDLE : S_WRITE;
      S_WRITE: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // ALU: carry/borrow is the extra top bit of the widened add/subtract
  always_comb begin
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    diff_s      = {1'b0, a_r} - {1'b0, b_r};
    alu_res_s   = {DATA_W{1'b0}};
    alu_c_s     = 1'b0;
    flags_upd_s = 1'b1;
    case (op_r)
      OP_MOV: alu_res_s = b_r;
      OP_ADD: begin
        alu_c_s = sum_s[DATA_W];
`ifdef SEQ_SAT_EN
        if (sum_s[DATA_W]) begin
          alu_res_s = {DATA_W{1'b1}};
        end else begin
          alu_res_s = sum_s[DATA_W-1:0];
        end
`else
        alu_res_s = sum_s[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        alu_c_s = diff_s[DATA_W];
`ifdef SEQ_SAT_EN
        if (diff_s[DATA_W]) begin
          alu_res_s = {DATA_W{1'b0}};
        end else begin
          alu_res_s = diff_s[DATA_W-1:0];
        end
`else
        alu_res_s = diff_s[DATA_W-1:0];
`endif
      end
      OP_AND: alu_res_s = a_r & b_r;
      OP_OR:  alu_res_s = a_r | b_r;
      OP_XOR: alu_res_s = a_r ^ b_r;
      OP_LDI: begin
        alu_res_s   = imm_r;
        flags_upd_s = 1'b0;
      end
      OP_CMP: begin
        alu_res_s = diff_s[DATA_W-1:0];
        alu_c_s   = diff_s[DATA_W];
      end
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  // State, command latch, operand capture and result/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      op_r     <= 3'b000;
      op1_r    <= {ADDR_W{1'b0}};
      op2_r    <= {ADDR_W{1'b0}};
      imm_r    <= {DATA_W{1'b0}};
      a_r      <= {DATA_W{1'b0}};
      b_r      <= {DATA_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
      z_r      <= 1'b0;
      c_r      <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_r == S_WRITE) || ((state_r == S_EXEC) && (op_r == OP_CMP));
      if ((state_r == S_IDLE) && cmd_valid) begin
        op_r  <= cmd_op;
        op1_r <= cmd_rd;
        op2_r <= cmd_rs;
        imm_r <= cmd_imm;
      end
      if (state_r == S_READ) begin
        a_r <= rf_out1;
        b_r <= rf_out2;
      end
      if (state_r == S_EXEC) begin
        if (op_r != OP_CMP) begin
          result_r <= alu_res_s;
        end
        if (flags_upd_s) begin
          z_r <= (alu_res_s == {DATA_W{1'b0}});
          c_r <= alu_c_s;
        end
      end
    end
  end

  // Write strobe is gated by rst_n so a reset during WRITE suppresses it at once
  assign cmd_ready   = (state_r == S_IDLE);
  assign rf_en_write = (state_r == S_WRITE) && rst_n;
  assign rf_op1      = op1_r;
  assign rf_op2      = op2_r;
  assign rf_data     = result_r;
  assign result      = result_r;
  assign done        = done_r;
  assign flag_z      = z_r;
  assign flag_c      = c_r;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: behavioural register-file/ALU model,
// per-cycle compare process, plus literal expectations for the directed scenarios.
module tb_reg_op_sequencer;

  localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, LDI = 3'd6, CMP = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, rf_en_write, done, flag_z, flag_c;
  logic [2:0] cmd_op, cmd_rd, cmd_rs, rf_op1, rf_op2;
  logic [7:0] cmd_imm, rf_data, rf_out1, rf_out2, result;

  always #5 clk = ~clk;

  reg_op_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_op1(rf_op1), .rf_op2(rf_op2), .rf_data(rf_data), .rf_en_write(rf_en_write),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  // Bench-side register file driven by the sequencer
  logic       tb_clr;
  logic [7:0] rf [8];
  assign rf_out1 = rf[rf_op1];
  assign rf_out2 = rf[rf_op2];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (rf_en_write) begin
      rf[rf_op1] <= rf_data;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected outputs for the current cycle
  logic       chk_en, chk_zero, exp_ready, exp_done, exp_we, exp_z, exp_c;
  logic [2:0] exp_op1;
  logic [7:0] exp_data, exp_result;
  logic [7:0] m_regs [8];

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("rf_en_write", {31'd0, rf_en_write}, {31'd0, exp_we});
      if (exp_we) begin
        check("wr_addr", {29'd0, rf_op1}, {29'd0, exp_op1});
        check("wr_data", {24'd0, rf_data}, {24'd0, exp_data});
      end
      if (exp_ready) begin
        check("result", {24'd0, result}, {24'd0, exp_result});
        check("rf_data_hold", {24'd0, rf_data}, {24'd0, exp_result});
        check("flag_z", {31'd0, flag_z}, {31'd0, exp_z});
        check("flag_c", {31'd0, flag_c}, {31'd0, exp_c});
      end
      if (chk_zero) begin
        check("rst_op1", {29'd0, rf_op1}, 32'd0);
        check("rst_op2", {29'd0, rf_op2}, 32'd0);
      end
    end
  end

  // Reference semantics from plain integer arithmetic
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] imm, output logic [7:0] res, output logic z,
                                output logic c, output logic upd, output logic wr, output int lat);
    int s;
    upd = 1'b1; wr = 1'b1; c = 1'b0; lat = 4; res = 8'h00;
    case (op)
      MOV:  res = b;
      ADD: begin
        s = int'(a) + int'(b);
        c = (s > 255);
`ifdef SEQ_SAT_EN
        res = c ? 8'hFF : 8'(s);
`else
        res = 8'(s % 256);
`endif
      end
      SUB: begin
        s = int'(a) - int'(b);
        c = (s < 0);
`ifdef SEQ_SAT_EN
        res = c ? 8'h00 : 8'(s);
`else
        res = 8'((s + 256) % 256);
`endif
      end
      AND_: res = a & b;
      OR_:  res = a | b;
      XOR_: res = a ^ b;
      LDI: begin res = imm; upd = 1'b0; lat = 3; end
      default: begin
        s = int'(a) - int'(b);
        c = (s < 0);
        res = 8'((s + 256) % 256);
        wr = 1'b0; lat = 3;
      end
    endcase
    z = (res == 8'h00);
  endfunction

  // Issue one command (entered at an IDLE cycle, returns in its done cycle)
  task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                     input logic [7:0] imm, input bit busy_pulse, input bit abort);
    logic [7:0] res;
    logic z, c, upd, wr;
    int lat;
    model(op, m_regs[rd], m_regs[rs], imm, res, z, c, upd, wr, lat);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      exp_ready = (k == lat);
      exp_done  = (k == lat);
      exp_we    = wr && (k == lat - 1);
      exp_op1   = rd;
      exp_data  = res;
      if (k == lat) begin
        if (op != CMP) exp_result = res;
        if (upd) begin exp_z = z; exp_c = c; end
        if (wr) m_regs[rd] = res;
      end
      if (busy_pulse && k < lat) begin
        cmd_valid = 1'b1; cmd_op = LDI; cmd_rd = rd ^ 3'd1; cmd_imm = 8'h5A;
      end else begin
        cmd_valid = 1'b0;
      end
      if (abort && k == lat - 1) begin
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        exp_we = 1'b0;
        @(posedge clk); #1;
        exp_ready = 1'b1; exp_done = 1'b0; exp_we = 1'b0;
        exp_result = 8'h00; exp_z = 1'b0; exp_c = 1'b0; chk_zero = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_zero = 1'b0;
        return;
      end
      if (k < lat) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_ready = 1'b1; exp_done = 1'b0; exp_we = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = ADD; cmd_rd = 3'd2; cmd_rs = 3'd5; cmd_imm = 8'h00;
    tb_clr = 1'b1; chk_en = 1'b0; chk_zero = 1'b1;
    exp_ready = 1'b1; exp_done = 1'b0; exp_we = 1'b0; exp_op1 = 3'd0; exp_data = 8'h00;
    exp_result = 8'h00; exp_z = 1'b0; exp_c = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

    // Reset held with cmd_valid high: nothing accepted, outputs at reset values
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tb_clr = 1'b0; cmd_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero = 1'b0;

    run(LDI, 3'd3, 3'd0, 8'hA5, 1'b0, 1'b0);
    check("t2_rf3", {24'd0, rf[3]}, 32'h0000_00A5);
    check("t2_result", {24'd0, result}, 32'h0000_00A5);

    run(LDI, 3'd1, 3'd0, 8'h01, 1'b0, 1'b0);
    run(LDI, 3'd2, 3'd0, 8'hF0, 1'b0, 1'b0);
    run(LDI, 3'd5, 3'd0, 8'h20, 1'b0, 1'b0);
    run(LDI, 3'd6, 3'd0, 8'h3C, 1'b0, 1'b0);
    run(LDI, 3'd4, 3'd0, 8'h77, 1'b0, 1'b0);

    run(ADD, 3'd2, 3'd5, 8'h00, 1'b0, 1'b0);
`ifdef SEQ_SAT_EN
    check("t3_add_sat", {24'd0, rf[2]}, 32'h0000_00FF);
`else
    check("t3_add_wrap", {24'd0, rf[2]}, 32'h0000_0010);
`endif
    check("t3_flag_c", {31'd0, flag_c}, 32'd1);
    check("t3_flag_z", {31'd0, flag_z}, 32'd0);

    run(CMP, 3'd1, 3'd1, 8'h00, 1'b0, 1'b0);
    check("t4_flag_z", {31'd0, flag_z}, 32'd1);
    check("t4_flag_c", {31'd0, flag_c}, 32'd0);

    idle(2);
    run(MOV, 3'd4, 3'd6, 8'h00, 1'b1, 1'b0);
    run(MOV, 3'd7, 3'd4, 8'h00, 1'b0, 1'b0);
    check("t5_rf7", {24'd0, rf[7]}, 32'h0000_003C);
    check("t5_rf5_untouched", {24'd0, rf[5]}, 32'h0000_0020);

    run(SUB, 3'd5, 3'd1, 8'h00, 1'b0, 1'b0);
    check("sub_rf5", {24'd0, rf[5]}, 32'h0000_001F);
    run(SUB, 3'd1, 3'd6, 8'h00, 1'b0, 1'b0);
`ifdef SEQ_SAT_EN
    check("sub_borrow_sat", {24'd0, rf[1]}, 32'h0000_0000);
`else
    check("sub_borrow_wrap", {24'd0, rf[1]}, 32'h0000_00C5);
`endif
    run(AND_, 3'd3, 3'd6, 8'h00, 1'b0, 1'b0);
    check("and_rf3", {24'd0, rf[3]}, 32'h0000_0024);
    run(OR_, 3'd4, 3'd5, 8'h00, 1'b0, 1'b0);
    run(XOR_, 3'd7, 3'd6, 8'h00, 1'b0, 1'b0);
    check("xor_zero", {31'd0, flag_z}, 32'd1);
    run(CMP, 3'd5, 3'd3, 8'h00, 1'b0, 1'b0);
    run(LDI, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
    check("ldi_keeps_c", {31'd0, flag_c}, 32'd1);
    check("ldi_keeps_z", {31'd0, flag_z}, 32'd0);
    run(ADD, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);

    idle(1);
    run(SUB, 3'd6, 3'd4, 8'h00, 1'b0, 1'b1);
    check("t6_rf6_kept", {24'd0, rf[6]}, 32'h0000_003C);
    run(MOV, 3'd0, 3'd6, 8'h00, 1'b0, 1'b0);
    check("t6_mov_r0", {24'd0, rf[0]}, 32'h0000_003C);

    idle(2);
    for (int i = 0; i < 8; i++) check("final_rf", {24'd0, rf[i]}, {24'd0, m_regs[i]});
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
